// File: rtl/target_picker.sv
`default_nettype none
// ============================================================================
// target_picker : draws a legal target index from the free-running rng value
//                 with bounded retries and a deterministic fallback.
// Optional macro TARGET_NO_REPEAT_EN rejects a repeat of the previous pick.
// Revision: 1.0
// ============================================================================
module target_picker #(
  parameter int NUM_TARGETS = 18,
  parameter int VALUE_WIDTH = 5,
  parameter int MAX_RETRIES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [VALUE_WIDTH-1:0] random_value,
  input  logic                   req,
  output logic                   valid,
  output logic [VALUE_WIDTH-1:0] target_idx,
  output logic [NUM_TARGETS-1:0] target_onehot,
  output logic                   busy,
  output logic                   fallback
);

  localparam int CNT_W = $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0]       LAST_RETRY  = CNT_W'(MAX_RETRIES - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(1);
  localparam logic [VALUE_WIDTH:0]   NUM_T_EXT   = (VALUE_WIDTH + 1)'(NUM_TARGETS);
  localparam logic [VALUE_WIDTH:0]   TOP_IDX_EXT = (VALUE_WIDTH + 1)'(NUM_TARGETS - 1);
  localparam logic [VALUE_WIDTH:0]   EXT_ONE     = (VALUE_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e                   state_q,    state_d;
  logic [CNT_W-1:0]         retry_q,    retry_d;
  logic                     last_ok_q,  last_ok_d;
  logic [VALUE_WIDTH-1:0]   last_idx_q, last_idx_d;
  logic                     valid_q,    valid_d;
  logic [VALUE_WIDTH-1:0]   idx_q,      idx_d;
  logic [NUM_TARGETS-1:0]   onehot_q,   onehot_d;
  logic                     fallback_q, fallback_d;

  logic                     w_in_range;
  logic                     w_repeat;
  logic                     w_accept;
  logic [VALUE_WIDTH:0]     w_next_ext;
  logic [VALUE_WIDTH-1:0]   w_fb_idx;

  function automatic logic [NUM_TARGETS-1:0] decode(input logic [VALUE_WIDTH-1:0] idx);
    logic [NUM_TARGETS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (idx == VALUE_WIDTH'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Range check is done one bit wider so NUM_TARGETS == 2**VALUE_WIDTH works.
  assign w_in_range = {1'b0, random_value} < NUM_T_EXT;

`ifdef TARGET_NO_REPEAT_EN
  assign w_repeat = last_ok_q && (random_value == last_idx_q);
`else
  assign w_repeat = 1'b0;
`endif

  assign w_accept   = w_in_range && !w_repeat;
  assign w_next_ext = {1'b0, last_idx_q} + EXT_ONE;

  // Successor of the previous pick, wrapping at the top index; 0 with no history.
  always_comb begin
    w_fb_idx = '0;
    if (last_ok_q && ({1'b0, last_idx_q} != TOP_IDX_EXT)) begin
      w_fb_idx = w_next_ext[VALUE_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    last_ok_d  = last_ok_q;
    last_idx_d = last_idx_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    onehot_d   = onehot_q;
    fallback_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SAMPLE;
          retry_d = '0;
        end
      end
      SAMPLE: begin
        if (w_accept) begin
          idx_d      = random_value;
          onehot_d   = decode(random_value);
          last_idx_d = random_value;
          last_ok_d  = 1'b1;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end else begin
          retry_d = retry_q + CNT_ONE;
          if (retry_q == LAST_RETRY) begin
            idx_d      = w_fb_idx;
            onehot_d   = decode(w_fb_idx);
            last_idx_d = w_fb_idx;
            last_ok_d  = 1'b1;
            valid_d    = 1'b1;
            fallback_d = 1'b1;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (!req) begin
          valid_d  = 1'b0;
          onehot_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      last_ok_q  <= 1'b0;
      last_idx_q <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      onehot_q   <= '0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      last_ok_q  <= last_ok_d;
      last_idx_q <= last_idx_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      onehot_q   <= onehot_d;
      fallback_q <= fallback_d;
    end
  end

  assign valid         = valid_q;
  assign target_idx    = idx_q;
  assign target_onehot = onehot_q;
  assign busy          = (state_q == SAMPLE);
  assign fallback      = fallback_q;

  a_busy_valid_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy && valid));
  a_onehot_idle:     assert property (@(posedge clk) disable iff (!rst_n) valid || (target_onehot == '0));

endmodule
`default_nettype wire

// File: tb/tb_target_picker.sv
`default_nettype none
// ============================================================================
// tb_target_picker : directed, table-driven bench for target_picker.
// Revision: 1.0
// ============================================================================
module tb_target_picker;

  localparam int NT = 18;
  localparam int VW = 5;

  logic          clk;
  logic          rst_n;
  logic [VW-1:0] random_value;
  logic          req;
  logic          valid;
  logic [VW-1:0] target_idx;
  logic [NT-1:0] target_onehot;
  logic          busy;
  logic          fallback;

  int n_cmp;
  int n_bad;

  target_picker #(.NUM_TARGETS(NT), .VALUE_WIDTH(VW), .MAX_RETRIES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .random_value  (random_value),
    .req           (req),
    .valid         (valid),
    .target_idx    (target_idx),
    .target_onehot (target_onehot),
    .busy          (busy),
    .fallback      (fallback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [VW-1:0] rv;
    logic [VW-1:0] idx;
    logic          fb;
    int            lat;
  } pick_t;

  pick_t vec[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [NT-1:0] oh_of(input logic [VW-1:0] i);
    logic [NT-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // One complete request/pick/release with random_value stuck at v.
  task automatic do_pick(input logic [VW-1:0] v, input logic [VW-1:0] exp_idx,
                         input logic exp_fb, input int exp_lat, input string tag);
    int n;
    bit got;
    @(negedge clk);
    random_value = v;
    req = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy_first"}, busy, 1);
    check({tag, " valid_early"}, valid, 0);
    n = 0;
    got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        got = 1;
        n = i;
      end
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " idx"}, target_idx, exp_idx);
    check({tag, " onehot"}, target_onehot, oh_of(exp_idx));
    check({tag, " fallback"}, fallback, exp_fb);
    check({tag, " busy_done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, " fb_pulse_end"}, fallback, 0);
    check({tag, " hold_valid"}, valid, 1);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop_valid"}, valid, 0);
    check({tag, " drop_onehot"}, target_onehot, 0);
    check({tag, " drop_idx_kept"}, target_idx, exp_idx);
  endtask

  initial begin
    logic [VW-1:0] rseq[4];
    int busy_cnt;
    logic [VW-1:0] held_idx;
    logic [NT-1:0] held_oh;

    n_cmp = 0;
    n_bad = 0;

    // Each row follows the last; no-repeat history carries between rows.
    vec[0] = '{rv: 5'd5,  idx: 5'd5,  fb: 1'b0, lat: 1};
    vec[1] = '{rv: 5'd7,  idx: 5'd7,  fb: 1'b0, lat: 1};
`ifdef TARGET_NO_REPEAT_EN
    vec[2] = '{rv: 5'd7,  idx: 5'd8,  fb: 1'b1, lat: 8};
    vec[3] = '{rv: 5'd25, idx: 5'd9,  fb: 1'b1, lat: 8};
`else
    vec[2] = '{rv: 5'd7,  idx: 5'd7,  fb: 1'b0, lat: 1};
    vec[3] = '{rv: 5'd25, idx: 5'd8,  fb: 1'b1, lat: 8};
`endif
    vec[4] = '{rv: 5'd17, idx: 5'd17, fb: 1'b0, lat: 1};
    vec[5] = '{rv: 5'd25, idx: 5'd0,  fb: 1'b1, lat: 8};
`ifdef TARGET_NO_REPEAT_EN
    vec[6] = '{rv: 5'd0,  idx: 5'd1,  fb: 1'b1, lat: 8};
    vec[7] = '{rv: 5'd18, idx: 5'd2,  fb: 1'b1, lat: 8};
    vec[8] = '{rv: 5'd31, idx: 5'd3,  fb: 1'b1, lat: 8};
`else
    vec[6] = '{rv: 5'd0,  idx: 5'd0,  fb: 1'b0, lat: 1};
    vec[7] = '{rv: 5'd18, idx: 5'd1,  fb: 1'b1, lat: 8};
    vec[8] = '{rv: 5'd31, idx: 5'd2,  fb: 1'b1, lat: 8};
`endif
    vec[9] = '{rv: 5'd16, idx: 5'd16, fb: 1'b0, lat: 1};

    rst_n = 1'b0;
    req = 1'b0;
    random_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", valid, 0);
    check("rst busy", busy, 0);
    check("rst fallback", fallback, 0);
    check("rst idx", target_idx, 0);
    check("rst onehot", target_onehot, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_pick(vec[i].rv, vec[i].idx, vec[i].fb, vec[i].lat, $sformatf("vec%0d", i));
    end

    // Range rejection with a changing value, then a long HOLD.
    rseq[0] = 5'd31; rseq[1] = 5'd20; rseq[2] = 5'd18; rseq[3] = 5'd3;
    busy_cnt = 0;
    @(negedge clk);
    req = 1'b1;
    random_value = rseq[0];
    @(posedge clk); #1;
    if (busy) busy_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      random_value = rseq[i];
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (i < 3) check($sformatf("range rej%0d valid", i), valid, 0);
    end
    check("range valid", valid, 1);
    check("range idx", target_idx, 3);
    check("range onehot", target_onehot, oh_of(5'd3));
    check("range fallback", fallback, 0);
    check("range busy_cycles", busy_cnt, 4);
    held_idx = target_idx;
    held_oh = target_onehot;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      random_value = 5'(i * 3);
      @(posedge clk); #1;
      check($sformatf("hold%0d stable", i),
            {valid, busy, fallback, target_idx, target_onehot},
            {1'b1, 1'b0, 1'b0, held_idx, held_oh});
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    check("hold drop valid", valid, 0);
    check("hold drop onehot", target_onehot, 0);

    // req drops while sampling: pick still completes, then IDLE.
    @(negedge clk);
    req = 1'b1;
    random_value = 5'd25;
    @(posedge clk); #1;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    check("middrop rej1 busy", busy, 1);
    @(posedge clk); #1;
    check("middrop rej2 busy", busy, 1);
    @(negedge clk);
    random_value = 5'd4;
    @(posedge clk); #1;
    check("middrop valid", valid, 1);
    check("middrop idx", target_idx, 4);
    @(posedge clk); #1;
    check("middrop release valid", valid, 0);
    check("middrop release busy", busy, 0);
    @(posedge clk); #1;
    check("middrop idle busy", busy, 0);

    // Asynchronous reset while in SAMPLE.
    @(negedge clk);
    req = 1'b1;
    random_value = 5'd30;
    @(posedge clk);
    @(posedge clk); #1;
    check("rstsample pre busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstsample outputs",
          {valid, busy, fallback, target_idx, target_onehot}, 0);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstsample idle", busy, 0);

    // Asynchronous reset while in HOLD, then history must be gone.
    @(negedge clk);
    req = 1'b1;
    random_value = 5'd7;
    @(posedge clk);
    @(posedge clk); #1;
    check("rsthold pre valid", valid, 1);
    check("rsthold pre idx", target_idx, 7);
    #1;
    rst_n = 1'b0;
    #1;
    check("rsthold outputs",
          {valid, busy, fallback, target_idx, target_onehot}, 0);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    do_pick(5'd7, 5'd7, 1'b0, 1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/target_picker.md
# target_picker

Consumer of the free-running `rng` output stream for the game logic. On a request it samples `random_value` and rejects out-of-range codes, plus repeats of the previous target when so configured. It returns one accepted target index and its one-hot LED mask through a four-phase req/valid handshake. A bounded retry count with a deterministic fallback keeps latency finite whatever the generator produces.

## Interface
- `NUM_TARGETS`, 18: number of targets; legal indices are 0..NUM_TARGETS-1; must be 2..2^VALUE_WIDTH.
- `VALUE_WIDTH`, 5: width of `random_value` and `target_idx`.
- `MAX_RETRIES`, 8: rejected samples tolerated before fallback; must be ≥1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `random_value` in VALUE_WIDTH: free-running value from `rng`; may change every cycle.
- `req` in 1: request level; four-phase handshake with `valid`.
- `valid` out 1: `target_idx`/`target_onehot` hold an accepted pick.
- `target_idx` out VALUE_WIDTH: accepted index.
- `target_onehot` out NUM_TARGETS: `1 << target_idx`; all-zero when `valid`=0.
- `busy` out 1: high in SAMPLE.
- `fallback` out 1: one-cycle pulse, coincident with `valid` rising, when the pick came from the fallback path.

## Operation
- Reset (async assert, sync release) values:
  - `valid`=0, `busy`=0, `fallback`=0, `target_idx`=0, `target_onehot`=0.
  - Retry counter=0, state=IDLE, `last_ok`=0, `last_idx`=0.
- **IDLE**: `req`=1 → SAMPLE and clear the retry counter; otherwise stay.
- **SAMPLE**: each cycle, register-sample `random_value` (v).
  - v is accepted if v < NUM_TARGETS and, when no-repeat is enabled, not (`last_ok` and v == `last_idx`).
  - Accept: `target_idx`=v, `valid`=1, `last_idx`=v, `last_ok`=1, go to HOLD.
  - Reject: retry counter +1. On the MAX_RETRIES-th consecutive reject, on that same edge:
    - take the fallback index f = `last_ok` ? (`last_idx`+1) mod NUM_TARGETS : 0;
    - `fallback`=1 for one cycle; update `last_idx`/`last_ok`; `valid`=1; go to HOLD.
  - The fallback index never equals `last_idx`.
- **HOLD**: outputs frozen while `req`=1. `req`=0 → `valid`=0, `target_onehot`=0, go to IDLE; `target_idx` keeps its last value.
- `req` dropping during SAMPLE is ignored: the pick completes, then HOLD sees `req`=0 and returns to IDLE one cycle later.
- Comparison is unsigned at VALUE_WIDTH bits. The `+1` wrap is computed at VALUE_WIDTH+1 bits before the compare to NUM_TARGETS-1.
- The retry counter is wide enough for MAX_RETRIES and never wraps.

## Timing
- `req` seen high at edge k (IDLE) → SAMPLE from k. The first sample is taken at edge k+1, so best-case `valid` is high after edge k+1 (2-cycle latency).
- Worst case, fallback: `valid` is high after edge k+MAX_RETRIES.
- `valid` falls one edge after `req` is seen low in HOLD. A new request needs `req` low for at least one edge while in IDLE or HOLD.
- `busy`=1 exactly during SAMPLE cycles; `busy` and `valid` are never both 1.
- `rst_n` low mid-SAMPLE or mid-HOLD clears everything immediately, including no-repeat history. The first pick after reset may be any legal index.

## Configuration
- Macro `TARGET_NO_REPEAT_EN`.
- Defined: a sample equal to `last_idx` (with `last_ok`=1) is rejected and counts as a retry.
- Undefined: only the range check applies. `last_idx`/`last_ok` are still maintained for the fallback computation. Consecutive identical picks are legal.

## Test plan
- **Basic pick:** reset, drive `random_value`=5, raise `req` → `valid`=1 two cycles later, `target_idx`=5, `target_onehot`=18'h00020, `fallback`=0.
- **Range rejection:** drive 31, 20, 18, then 3, with `req` held → `valid` on the 4th sample with `target_idx`=3, `busy` high for 4 cycles.
- **No-repeat**, with `TARGET_NO_REPEAT_EN`:
  - take pick 7, drop `req`, re-request with `random_value` fixed at 7 → after 8 rejects, `target_idx`=8 and `fallback` pulses once;
  - repeat the same stimulus without the macro → `target_idx`=7 immediately.
- **Wrap fallback:** last pick 17, re-request with `random_value` stuck at 25 → `target_idx`=0, `fallback`=1 after MAX_RETRIES edges.
- **Handshake:**
  - hold `req` high for 10 cycles in HOLD → outputs stable throughout;
  - drop `req` → `valid`=0 and `target_onehot`=0 next edge;
  - drop `req` mid-SAMPLE → pick completes, then returns to IDLE.
- **Reset mid-operation:** assert `rst_n`=0 during SAMPLE and during HOLD → all outputs 0 asynchronously. After release with `random_value`=7 and no-repeat enabled, 7 is accepted because history was cleared.
